// File: rtl/osc_ring_ctrl.sv
// osc_ring_ctrl: digital controller for an N-stage ring oscillator.
// Sequences start/settle/run for the ring enable. Double-buffers the per-stage
// delay and perturbation codes so that every stage retunes on the same edge.
// Generates the edge-injector enable in off/continuous/periodic/single-shot modes.
//
// Control semantics: osc_start, osc_stop, cfg_wr and cfg_commit are level
// requests sampled on each ref_clk rising edge. There is no back-pressure: a
// request is either acted on at that edge or dropped (osc_start outside IDLE,
// or a cfg_wr to a stage that does not exist).
module osc_ring_ctrl #(
  parameter int N_STAGE  = 5,
  parameter int LSB_W    = 5,
  parameter int MSB_W    = 8,
  parameter int PERB_W   = 4,
  parameter int SETTLE_W = 8,
  parameter int DIV_W    = 4,
  parameter int SEL_W    = $clog2(N_STAGE)
) (
  input  logic                      ref_clk,
  input  logic                      rstb,
  input  logic                      osc_start,
  input  logic                      osc_stop,
  input  logic [SETTLE_W-1:0]       settle_cycles,
  input  logic                      cfg_wr,
  input  logic [SEL_W-1:0]          cfg_stage,
  input  logic [LSB_W-1:0]          cfg_lsb,
  input  logic [MSB_W-1:0]          cfg_msb,
  input  logic [PERB_W-1:0]         cfg_perb,
  input  logic                      cfg_commit,
  input  logic [1:0]                inj_mode,
  input  logic [DIV_W-1:0]          inj_div,
  output logic                      glob_en,
  output logic [N_STAGE*LSB_W-1:0]  delay_con_lsb,
  output logic [N_STAGE*MSB_W-1:0]  delay_con_msb,
  output logic [N_STAGE*PERB_W-1:0] con_perb,
  output logic                      inj_en,
  output logic [1:0]                osc_state,
  output logic                      osc_ready,
  output logic                      cfg_err
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_RUN    = 2'b10
  } state_t;

  localparam logic [SEL_W:0] NS_LIM = (SEL_W+1)'(N_STAGE);

  state_t                    r_state, w_state_nxt;
  logic [SETTLE_W-1:0]       r_settle, w_settle_nxt;
  logic [DIV_W-1:0]          r_div, w_div_nxt;
  logic [1:0]                r_mode;
  logic                      r_inj_en, w_inj_nxt;
  logic                      w_run_nxt, w_run_entry;
  logic                      r_cfg_err;
  logic                      w_stage_ok;
  logic [N_STAGE*LSB_W-1:0]  r_sh_lsb, r_act_lsb, w_sh_lsb_nxt;
  logic [N_STAGE*MSB_W-1:0]  r_sh_msb, r_act_msb, w_sh_msb_nxt;
  logic [N_STAGE*PERB_W-1:0] r_sh_perb, r_act_perb, w_sh_perb_nxt;

  // Next-state and settle countdown; stop wins over start and over settle expiry.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = r_settle;
    case (r_state)
      ST_IDLE: begin
        if (osc_start && !osc_stop) begin
          w_state_nxt  = ST_SETTLE;
          w_settle_nxt = settle_cycles;
        end
      end
      ST_SETTLE: begin
        if (osc_stop) begin
          w_state_nxt = ST_IDLE;
        end else if (r_settle == '0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_settle_nxt = r_settle - SETTLE_W'(1);
        end
      end
      ST_RUN: begin
        if (osc_stop) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Injection enable for the coming cycle; the divider restarts on RUN entry
  // and whenever periodic mode is newly selected.
  always_comb begin
    w_run_nxt   = (w_state_nxt == ST_RUN);
    w_run_entry = w_run_nxt && (r_state != ST_RUN);
    w_div_nxt   = '0;
    if (w_run_nxt && !w_run_entry && (inj_mode == 2'b10) && (r_mode == 2'b10)) begin
      w_div_nxt = (r_div == inj_div) ? '0 : r_div + DIV_W'(1);
    end
    w_inj_nxt = 1'b0;
    if (w_run_nxt) begin
      case (inj_mode)
        2'b01:   w_inj_nxt = 1'b1;
        2'b10:   w_inj_nxt = (w_div_nxt == '0);
        2'b11:   w_inj_nxt = w_run_entry;
        default: w_inj_nxt = 1'b0;
      endcase
    end
  end

  // Sequencer, settle counter, divider and injector registers.
  always_ff @(posedge ref_clk) begin
    if (!rstb) begin
      r_state  <= ST_IDLE;
      r_settle <= '0;
      r_div    <= '0;
      r_mode   <= 2'b00;
      r_inj_en <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
      r_div    <= w_div_nxt;
      r_mode   <= inj_mode;
      r_inj_en <= w_inj_nxt;
    end
  end

  // Shadow code update; a same-cycle write is visible to a same-cycle commit.
  always_comb begin
    w_stage_ok    = ({1'b0, cfg_stage} < NS_LIM);
    w_sh_lsb_nxt  = r_sh_lsb;
    w_sh_msb_nxt  = r_sh_msb;
    w_sh_perb_nxt = r_sh_perb;
    for (int i = 0; i < N_STAGE; i++) begin
      if (cfg_wr && w_stage_ok && (cfg_stage == SEL_W'(i))) begin
        w_sh_lsb_nxt[i*LSB_W +: LSB_W]    = cfg_lsb;
        w_sh_msb_nxt[i*MSB_W +: MSB_W]    = cfg_msb;
        w_sh_perb_nxt[i*PERB_W +: PERB_W] = cfg_perb;
      end
    end
  end

  // Shadow/active code banks and the sticky bad-stage flag.
  always_ff @(posedge ref_clk) begin
    if (!rstb) begin
      r_sh_lsb   <= '0;
      r_sh_msb   <= '0;
      r_sh_perb  <= '0;
      r_act_lsb  <= '0;
      r_act_msb  <= '0;
      r_act_perb <= '0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_sh_lsb  <= w_sh_lsb_nxt;
      r_sh_msb  <= w_sh_msb_nxt;
      r_sh_perb <= w_sh_perb_nxt;
      if (cfg_commit) begin
        r_act_lsb  <= w_sh_lsb_nxt;
        r_act_msb  <= w_sh_msb_nxt;
        r_act_perb <= w_sh_perb_nxt;
      end
      if (cfg_wr && !w_stage_ok) begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  assign glob_en       = (r_state != ST_IDLE);
  assign osc_ready     = (r_state == ST_RUN);
  assign osc_state     = r_state;
  assign inj_en        = r_inj_en;
  assign cfg_err       = r_cfg_err;
  assign delay_con_lsb = r_act_lsb;
  assign delay_con_msb = r_act_msb;
  assign con_perb      = r_act_perb;

endmodule

// File: tb/tb_osc_ring_ctrl.sv
// Directed bench for osc_ring_ctrl with hand-computed expectations.
module tb_osc_ring_ctrl;

  logic        ref_clk = 1'b0;
  logic        rstb = 1'b0;
  logic        osc_start = 1'b0;
  logic        osc_stop = 1'b0;
  logic [7:0]  settle_cycles = '0;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_stage = '0;
  logic [4:0]  cfg_lsb = '0;
  logic [7:0]  cfg_msb = '0;
  logic [3:0]  cfg_perb = '0;
  logic        cfg_commit = 1'b0;
  logic [1:0]  inj_mode = '0;
  logic [3:0]  inj_div = '0;
  logic        glob_en;
  logic [24:0] delay_con_lsb;
  logic [39:0] delay_con_msb;
  logic [19:0] con_perb;
  logic        inj_en;
  logic [1:0]  osc_state;
  logic        osc_ready;
  logic        cfg_err;

  int n_vec = 0;
  int n_fail = 0;
  logic [7:0] per_pat;

  osc_ring_ctrl dut (
    .ref_clk(ref_clk), .rstb(rstb), .osc_start(osc_start), .osc_stop(osc_stop),
    .settle_cycles(settle_cycles), .cfg_wr(cfg_wr), .cfg_stage(cfg_stage),
    .cfg_lsb(cfg_lsb), .cfg_msb(cfg_msb), .cfg_perb(cfg_perb),
    .cfg_commit(cfg_commit), .inj_mode(inj_mode), .inj_div(inj_div),
    .glob_en(glob_en), .delay_con_lsb(delay_con_lsb), .delay_con_msb(delay_con_msb),
    .con_perb(con_perb), .inj_en(inj_en), .osc_state(osc_state),
    .osc_ready(osc_ready), .cfg_err(cfg_err)
  );

  // Clock.
  always #5 ref_clk = ~ref_clk;

  // Advance one edge and settle past it before sampling.
  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset then idle
    rstb = 1'b0;
    tick(); tick();
    rstb = 1'b1;
    tick();
    check("rst_glob", 64'(glob_en), 64'd0);
    check("rst_state", 64'(osc_state), 64'd0);
    check("rst_ready", 64'(osc_ready), 64'd0);
    check("rst_inj", 64'(inj_en), 64'd0);
    check("rst_lsb", 64'(delay_con_lsb), 64'd0);
    check("rst_msb", 64'(delay_con_msb), 64'd0);
    check("rst_perb", 64'(con_perb), 64'd0);
    check("rst_err", 64'(cfg_err), 64'd0);

    // Double buffer: write stage 2, outputs hold until commit
    cfg_wr = 1'b1; cfg_stage = 3'd2; cfg_lsb = 5'h1F; cfg_msb = 8'hA5; cfg_perb = 4'h9;
    tick();
    cfg_wr = 1'b0;
    check("pre_commit_lsb", 64'(delay_con_lsb), 64'd0);
    check("pre_commit_msb", 64'(delay_con_msb), 64'd0);
    check("pre_commit_perb", 64'(con_perb), 64'd0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("commit_lsb", 64'(delay_con_lsb), 64'h7C00);
    check("commit_msb", 64'(delay_con_msb), 64'hA5_0000);
    check("commit_perb", 64'(con_perb), 64'h900);

    // Write and commit in the same cycle (stage 0, then stage 4)
    cfg_wr = 1'b1; cfg_commit = 1'b1; cfg_stage = 3'd0;
    cfg_lsb = 5'h03; cfg_msb = 8'h11; cfg_perb = 4'h5;
    tick();
    check("wc_lsb", 64'(delay_con_lsb), 64'h7C03);
    check("wc_msb", 64'(delay_con_msb), 64'hA5_0011);
    check("wc_perb", 64'(con_perb), 64'h905);
    cfg_stage = 3'd4; cfg_lsb = 5'h15; cfg_msb = 8'hC3; cfg_perb = 4'hE;
    tick();
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    check("wc4_lsb", 64'(delay_con_lsb), 64'h150_7C03);
    check("wc4_msb", 64'(delay_con_msb), 64'hC3_00A5_0011);
    check("wc4_perb", 64'(con_perb), 64'hE0905);
    check("err_clean", 64'(cfg_err), 64'd0);

    // Out-of-range stage: discarded, sticky error through commit
    cfg_wr = 1'b1; cfg_stage = 3'd5; cfg_lsb = 5'h0A; cfg_msb = 8'hFF; cfg_perb = 4'hF;
    tick();
    cfg_wr = 1'b0;
    check("bad_err", 64'(cfg_err), 64'd1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("bad_lsb", 64'(delay_con_lsb), 64'h150_7C03);
    check("bad_msb", 64'(delay_con_msb), 64'hC3_00A5_0011);
    check("bad_perb", 64'(con_perb), 64'hE0905);
    check("bad_err_hold", 64'(cfg_err), 64'd1);

    // Start with settle_cycles=3, periodic injection inj_div=2
    inj_mode = 2'b10; inj_div = 4'd2; settle_cycles = 8'd3; osc_start = 1'b1;
    tick();
    osc_start = 1'b0; settle_cycles = 8'd0;
    check("settle_state_t1", 64'(osc_state), 64'd1);
    check("settle_glob_t1", 64'(glob_en), 64'd1);
    check("settle_ready_t1", 64'(osc_ready), 64'd0);
    check("settle_inj_t1", 64'(inj_en), 64'd0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check("settle_state", 64'(osc_state), 64'd1);
    end
    tick();
    check("run_state_t5", 64'(osc_state), 64'd2);
    check("run_ready_t5", 64'(osc_ready), 64'd1);
    check("per_inj_0", 64'(inj_en), 64'd1);
    per_pat = 8'b0100_1001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("per_inj", 64'(inj_en), 64'(per_pat[k]));
    end

    // Commit is legal in RUN
    cfg_wr = 1'b1; cfg_commit = 1'b1; cfg_stage = 3'd1; cfg_lsb = 5'h01; cfg_msb = 8'h02; cfg_perb = 4'h3;
    tick();
    cfg_wr = 1'b0; cfg_commit = 1'b0;
    check("run_commit_lsb", 64'(delay_con_lsb), 64'h150_7C23);

    // Mode changes mid-RUN: 11 gives no pulse, 01 continuous, 00 off, 10 restarts
    inj_mode = 2'b11;
    tick(); check("ss_mid_0", 64'(inj_en), 64'd0);
    tick(); check("ss_mid_1", 64'(inj_en), 64'd0);
    inj_mode = 2'b01;
    tick(); check("cont_0", 64'(inj_en), 64'd1);
    tick(); check("cont_1", 64'(inj_en), 64'd1);
    inj_mode = 2'b00;
    tick(); check("off_0", 64'(inj_en), 64'd0);
    inj_mode = 2'b10;
    tick(); check("per_restart_0", 64'(inj_en), 64'd1);
    tick(); check("per_restart_1", 64'(inj_en), 64'd0);
    tick(); check("per_restart_2", 64'(inj_en), 64'd0);
    tick(); check("per_restart_3", 64'(inj_en), 64'd1);

    // osc_start in RUN ignored
    osc_start = 1'b1;
    tick();
    osc_start = 1'b0;
    check("start_in_run", 64'(osc_state), 64'd2);

    // Stop from RUN
    osc_stop = 1'b1;
    tick();
    osc_stop = 1'b0;
    check("stop_state", 64'(osc_state), 64'd0);
    check("stop_glob", 64'(glob_en), 64'd0);
    check("stop_ready", 64'(osc_ready), 64'd0);
    check("stop_inj", 64'(inj_en), 64'd0);

    // Single-shot with settle_cycles=0: one SETTLE cycle, one pulse
    inj_mode = 2'b11; settle_cycles = 8'd0; osc_start = 1'b1;
    tick();
    osc_start = 1'b0;
    check("ss_settle", 64'(osc_state), 64'd1);
    check("ss_settle_inj", 64'(inj_en), 64'd0);
    tick();
    check("ss_run", 64'(osc_state), 64'd2);
    check("ss_pulse", 64'(inj_en), 64'd1);
    tick(); check("ss_after_0", 64'(inj_en), 64'd0);
    tick(); check("ss_after_1", 64'(inj_en), 64'd0);
    osc_stop = 1'b1;
    tick();
    osc_stop = 1'b0;

    // Start and stop together in SETTLE
    inj_mode = 2'b01; settle_cycles = 8'd5; osc_start = 1'b1;
    tick();
    check("prio_in_settle", 64'(osc_state), 64'd1);
    osc_stop = 1'b1;
    tick();
    osc_start = 1'b0; osc_stop = 1'b0;
    check("prio_state", 64'(osc_state), 64'd0);
    check("prio_glob", 64'(glob_en), 64'd0);
    check("prio_inj", 64'(inj_en), 64'd0);

    // Stop on the settle expiry cycle never reaches RUN
    settle_cycles = 8'd1; osc_start = 1'b1;
    tick();
    osc_start = 1'b0;
    tick();
    check("exp_settle", 64'(osc_state), 64'd1);
    osc_stop = 1'b1;
    tick();
    osc_stop = 1'b0;
    check("exp_stop_state", 64'(osc_state), 64'd0);
    check("exp_stop_inj", 64'(inj_en), 64'd0);
    tick();
    check("exp_stay_idle", 64'(osc_state), 64'd0);

    // Reset mid-RUN clears everything on the next edge
    settle_cycles = 8'd0; osc_start = 1'b1;
    tick();
    osc_start = 1'b0;
    tick();
    check("pre_rst_run", 64'(osc_state), 64'd2);
    check("pre_rst_inj", 64'(inj_en), 64'd1);
    rstb = 1'b0;
    tick();
    check("mid_rst_glob", 64'(glob_en), 64'd0);
    check("mid_rst_state", 64'(osc_state), 64'd0);
    check("mid_rst_inj", 64'(inj_en), 64'd0);
    check("mid_rst_err", 64'(cfg_err), 64'd0);
    check("mid_rst_lsb", 64'(delay_con_lsb), 64'd0);
    rstb = 1'b1;
    tick();
    check("post_rst_state", 64'(osc_state), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
